// File: rtl/imem_arbiter.sv
// Arbitrates one single-port synchronous-read instruction memory between CPU fetch and the
// program loader, steering read data back to whichever port issued the read.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnLoader} owner_e;

  logic [StreakW-1:0] streak_q, streak_d;
  owner_e             owner_q, owner_d;

  // Loader wins ties until it has taken MAX_STREAK grants in a row over a waiting fetch.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (f_req && (!l_req || streak_q == StreakMax)) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    streak_d = streak_q;
    owner_d  = OwnNone;
    if (f_gnt) begin
      streak_d = '0;
      owner_d  = OwnFetch;
    end else if (l_gnt) begin
      if (!f_req) begin
        streak_d = '0;
      end else if (streak_q != StreakMax) begin
        streak_d = streak_q + 1'b1;
      end
      owner_d = l_we ? OwnNone : OwnLoader;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      owner_q  <= OwnNone;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  // Masking with rst drops a read that was in flight when reset arrived.
  assign f_rvalid = !rst && (owner_q == OwnFetch);
  assign l_rvalid = !rst && (owner_q == OwnLoader);
  assign f_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a behavioural memory and reference model.
module tb_imem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] f_addr = '0, l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we;
  logic [DW-1:0] f_rdata, l_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] phys [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      else        mem_rdata <= phys[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int cyc; logic [DW-1:0] data;} exp_t;
  exp_t fq[$];
  exp_t lq[$];

  int    run = 0;
  logic  f_gnt_obs = 1'b0, l_gnt_obs = 1'b0;
  bit    log_en = 1'b0;
  string gseq = "";

  // Reference model: who should win this cycle, what the memory sees, what reads return.
  always @(negedge clk) begin
    logic ef, el;
    ef = !rst && f_req && (!l_req || run == MAX);
    el = !rst && l_req && !ef;
    chk("f_gnt", f_gnt, ef);
    chk("l_gnt", l_gnt, el);
    chk("mem_en", mem_en, ef || el);
    chk("mem_we", mem_we, el && l_we);
    if (ef) begin
      chk("mem_addr_f", mem_addr, f_addr);
      fq.push_back('{cyc, ref_mem[f_addr]});
    end
    if (el) begin
      chk("mem_addr_l", mem_addr, l_addr);
      if (l_we) begin
        chk("mem_wdata", mem_wdata, l_wdata);
        ref_mem[l_addr] = l_wdata;
      end else begin
        lq.push_back('{cyc, ref_mem[l_addr]});
      end
    end
    if (rst)                run = 0;
    else if (ef)            run = 0;
    else if (el && f_req)   run = (run < MAX) ? run + 1 : MAX;
    else if (el)            run = 0;
    f_gnt_obs = f_gnt;
    l_gnt_obs = l_gnt;
    if (log_en) gseq = {gseq, f_gnt ? "F" : (l_gnt ? "L" : "-")};
  end

  // Monitor: a read granted last cycle must return now unless reset intervened.
  always @(negedge clk) begin
    bit due, ev;
    due = fq.size() > 0 && fq[0].cyc == cyc - 1;
    ev  = due && !rst;
    chk("f_rvalid", f_rvalid, ev);
    if (due) begin
      if (ev && f_rvalid) chk("f_rdata", f_rdata, fq[0].data);
      void'(fq.pop_front());
    end
    due = lq.size() > 0 && lq[0].cyc == cyc - 1;
    ev  = due && !rst;
    chk("l_rvalid", l_rvalid, ev);
    if (due) begin
      if (ev && l_rvalid) chk("l_rdata", l_rdata, lq[0].data);
      void'(lq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0;
    l_req = 1'b0;
    l_we  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      phys[i]    = $urandom;
      ref_mem[i] = phys[i];
    end
    phys[0] = 32'h8C0107E8; ref_mem[0] = 32'h8C0107E8;
    phys[1] = 32'h00221020; ref_mem[1] = 32'h00221020;
    phys[2] = 32'h8C0107EC; ref_mem[2] = 32'h8C0107EC;

    // Reset with both requesting; first released cycle must favour the loader.
    rst = 1'b1; f_req = 1'b1; f_addr = 8'd9; l_req = 1'b1; l_addr = 8'd10;
    step(); step();
    rst = 1'b0;
    step();
    idle();
    step();

    // Fetch-only streaming.
    f_req = 1'b1; f_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (f_gnt_obs) f_addr = f_addr + 1'b1;
    end
    idle();
    step();

    // Starvation bound with both held.
    gseq = "";
    f_req = 1'b1; f_addr = 8'd30; l_req = 1'b1; l_we = 1'b0; l_addr = 8'd40;
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (f_gnt_obs) f_addr = f_addr + 1'b1;
      if (l_gnt_obs) l_addr = l_addr + 1'b1;
    end
    log_en = 1'b0;
    idle();
    checks++;
    if (gseq != "LLLLFLLLLF") begin
      errors++;
      $display("FAIL grant_seq: got %s expected LLLLFLLLLF", gseq);
    end
    step();

    // Loader write then read-back.
    l_req = 1'b1; l_we = 1'b1; l_addr = 8'd20; l_wdata = 32'hAC0207D0;
    step();
    l_we = 1'b0;
    step();
    idle();
    step();

    // Mixed ownership.
    f_req = 1'b1; f_addr = 8'd3;
    step();
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 8'd5;
    step();
    idle();
    step(); step();

    // Reset while a fetch read is in flight.
    f_req = 1'b1; f_addr = 8'd7;
    step();
    rst = 1'b1; f_req = 1'b0;
    step();
    rst = 1'b0;
    step(); step();

    // Randomized traffic across several load mixes, with occasional resets.
    for (int mix = 0; mix < 3; mix++) begin
      int pf, pl;
      pf = (mix == 0) ? 50 : (mix == 1) ? 90 : 20;
      pl = (mix == 0) ? 50 : (mix == 1) ? 90 : 80;
      for (int n = 0; n < 1000; n++) begin
        rst = ($urandom_range(0, 96) == 0);
        if (!f_req || f_gnt_obs) begin
          f_req  = ($urandom_range(0, 99) < pf);
          f_addr = AW'($urandom);
        end
        if (!l_req || l_gnt_obs) begin
          l_req   = ($urandom_range(0, 99) < pl);
          l_we    = ($urandom_range(0, 2) == 0);
          l_addr  = AW'($urandom_range(0, 15));
          l_wdata = $urandom;
        end else if ($urandom_range(0, 19) == 0) begin
          l_req = 1'b0;
        end
        step();
      end
    end

    rst = 1'b0;
    idle();
    step(); step(); step();
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("lq_drained", 32'(lq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters: the CPU fetch port (read-only) and the program-loader/debug port (read/write).
- Sits between the fetch stage and the instruction memory.
- Grants at most one memory access per cycle and routes the read data, which arrives one cycle later, back to the requester that issued the read.
- Has a bounded-starvation priority scheme so the loader cannot lock out fetch indefinitely.

Parameters:
ADDR_W, 8, width of word-index address (memory indexed directly by word, no byte offset)
DATA_W, 32, instruction/data word width
MAX_STREAK, 4, max consecutive loader grants while fetch is pending before fetch is forced a grant (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
f_req  in  1  fetch read request, held until granted
f_addr  in  ADDR_W  fetch word address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  fetch read data valid (registered)
f_rdata  out  DATA_W  fetch read data
l_req  in  1  loader request, held until granted
l_we  in  1  loader write (1) / read (0)
l_addr  in  ADDR_W  loader word address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader request accepted this cycle (combinational)
l_rvalid  out  1  loader read data valid (registered)
l_rdata  out  DATA_W  loader read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read is enabled

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: streak counter=0; in-flight owner=NONE; f_rvalid=0; l_rvalid=0.
- While rst=1: f_gnt=0, l_gnt=0, mem_en=0, mem_we=0.
- Grant logic (combinational from req, streak):
  - only f_req -> f_gnt=1.
  - only l_req -> l_gnt=1.
  - both, streak<MAX_STREAK -> l_gnt=1.
  - both, streak==MAX_STREAK -> f_gnt=1.
  - neither -> no grant.
  - Never both grants in one cycle.
- Memory drive:
  - Fetch granted: mem_en=1, mem_we=0, mem_addr=f_addr.
  - Loader granted: mem_en=1, mem_we=l_we, mem_addr=l_addr, mem_wdata=l_wdata.
  - No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata don't-care (drive 0).
- Streak counter, updated at the clock edge:
  - Loader granted while f_req=1: streak+1, saturating at MAX_STREAK.
  - Fetch granted: reset to 0.
  - Loader granted with f_req=0: stays 0.
  - No grant: holds its value.
- Read return:
  - On a granted read, the in-flight owner register is set to FETCH or LOADER at the edge; writes set it to NONE.
  - Next cycle: the owner's rvalid=1 and its rdata=mem_rdata; the other rvalid=0.
  - Latency: request granted in cycle N -> rvalid in cycle N+1.
  - rdata of a non-valid port is don't-care (drive mem_rdata).
- Back-to-back: a new grant is allowed every cycle, including the same cycle an rvalid is asserted; fully pipelined, throughput 1 access/cycle.
- Loader writes: no rvalid. Write-then-read of the same address on consecutive cycles returns the new data (memory is write-first at the next edge).
- Reset mid-operation: an in-flight read is dropped; no rvalid follows the reset cycle.
- Requesters must hold req/addr/we/wdata stable until gnt; deasserting req before gnt withdraws the request with no side effect.
- Address wrap: none internal; addresses pass through unmodified.

Test Plan:
- Reset: rst=1 two cycles with f_req=l_req=1 -> all gnt/rvalid/mem_en=0; after release, streak=0 and first cycle grants loader.
- Fetch only: f_req=1, f_addr=0,1,2 over consecutive cycles, mem preloaded 0x8C0107E8,0x00221020,0x8C0107EC -> f_gnt=1 each cycle; f_rvalid=1 from the second cycle with those words in order.
- Starvation bound, MAX_STREAK=4: f_req and l_req held 1 (loader reads) -> grant sequence L,L,L,L,F,L,L,L,L,F; f_rvalid exactly once after each F.
- Loader write/read-back: l_we=1, addr=20, wdata=0xAC0207D0; then l_we=0, addr=20 -> no rvalid after the write; l_rvalid=1 with 0xAC0207D0 the cycle after the read grant; f_rvalid stays 0.
- Mixed ownership: fetch read addr 3 in cycle N, loader read addr 5 in cycle N+1 -> f_rvalid only at N+1 (mem[3]); l_rvalid only at N+2 (mem[5]).
- Reset mid-flight: fetch read granted cycle N, rst=1 at cycle N+1 -> f_rvalid=0 at N+1 and N+2; streak=0.
